uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Transmit byte queue that sits directly upstream of the UART transmitter. The host/bus side pushes bytes. The transmitter consumes them through a first-word-fall-through (FWFT) head interface, using its `queue_not_empty` / `tx_data` / `tx_started` handshake. The queue is a circular buffer with occupancy count, full/empty status and sticky error flags.

## Interface
- `DEPTH`, default 8: number of byte entries. Must be a power of two, 2..256.
- `WIDTH`, default 8: data width. Fixed at 8 for the UART path.
- `clk` input 1: system clock (50 MHz). All state updates on posedge.
- `rst` input 1: reset. One clock; reset is asynchronous and active-high.
- `wr_en` input 1: push request, one byte per cycle.
- `wr_data` input WIDTH: byte to push, sampled when `wr_en` is high.
- `tx_started` input 1: pop strobe from the transmitter. Single-cycle pulse.
- `clr_errs` input 1: synchronous clear of the `overflow` and `underflow` flags.
- `queue_not_empty` output 1: head entry is valid.
- `tx_data` output WIDTH: head byte (FWFT). Reads 8'h00 when empty.
- `full` output 1: count == DEPTH.
- `count` output $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow` output 1: sticky. Set when a push is rejected.
- `underflow` output 1: sticky. Set when a pop is ignored.

## Operation
- **Storage:** DEPTH x WIDTH register array. Write pointer `wr_ptr` and read pointer `rd_ptr` are each $clog2(DEPTH) bits and wrap modulo DEPTH naturally. `count` is a separate register. Empty/full derive from `count` only.
- **Push accepted** when `wr_en && !full`. On accept: write `mem[wr_ptr] <= wr_data` and increment `wr_ptr`.
- **Push rejected** when `wr_en && full`. This holds even if `tx_started` is high in the same cycle. No write, no pointer change, and `overflow` is set.
- **Pop accepted** when `tx_started && queue_not_empty`, where `queue_not_empty` is the pre-edge value. On accept: increment `rd_ptr`.
- **Pop ignored** when `tx_started && !queue_not_empty`. No pointer change, and `underflow` is set.
- **Count update:**
  - +1 if push accepted and no pop accepted.
  - −1 if pop accepted and no push accepted.
  - Unchanged if both or neither are accepted.
- **Simultaneous events:**
  - Push+pop on empty: push accepted, pop ignored (underflow set), count becomes 1.
  - Push+pop on full: pop accepted, push rejected (overflow set), count becomes DEPTH−1.
  - Push+pop with 0 < count < DEPTH: both accepted, count unchanged.
- **Head output:** `tx_data = queue_not_empty ? mem[rd_ptr] : 0`. This is combinational from registers; no read latency.
- **Status outputs:** `queue_not_empty = (count != 0)` and `full = (count == DEPTH)`. Both are combinational from the `count` register.
- **Error flags:** `clr_errs` clears both flags. If an error event occurs in the same cycle as `clr_errs`, the set wins.
- **Contents:** memory contents are not reset; only pointers, count and flags are.

## Timing
- **Reset** (asynchronous, while `rst` is high):
  - `wr_ptr` = 0, `rd_ptr` = 0, `count` = 0.
  - `overflow` = 0, `underflow` = 0.
  - Hence `queue_not_empty` = 0, `full` = 0, `tx_data` = 8'h00.
- **Mid-operation reset:** all queued bytes are discarded immediately. `queue_not_empty` drops asynchronously, so a downstream transmitter in IDLE starts nothing new.
- **Push-to-visible latency:** 1 cycle. A byte pushed at edge N appears on `tx_data` with `queue_not_empty` = 1 after edge N.
- **Pop-to-next-head latency:** 1 cycle. After the edge sampling `tx_started`, `tx_data` shows the next entry, or 0 if the queue is now empty.
- **Consumer contract:**
  - The transmitter samples `tx_data` on its init cycle and pulses `tx_started` on the following cycle.
  - The head must not change between those two cycles. This holds because only a pop advances `rd_ptr`.
- **Throughput:** one push per cycle sustained on the write side. Pops are limited by the transmitter to one per byte time.
- **Registered outputs:** `count`, `overflow` and `underflow` are registered. `full`, `queue_not_empty` and `tx_data` are combinational from registers only, with no input-to-output paths.

## Test plan
- **Reset state:** assert `rst` mid-run with count=5. Required: `count`=0, `queue_not_empty`=0, `tx_data`=8'h00 while `rst` is high. After release, push 8'hA5 → `tx_data`=8'hA5 next cycle.
- **Ordering and wrap:** push 8'h01..8'h08 (DEPTH=8) → `full`=1, `count`=8. Pop 3 → `tx_data`=8'h04. Push 8'h09..8'h0B → pointers wrap. Draining 8 pops yields 8'h04..8'h0B in order, then `queue_not_empty`=0.
- **Full boundary:** at count=8, `wr_en` with `tx_started` → `count`=7, `overflow`=1, and the pushed byte never appears. With `clr_errs` held on the next cycle and no error event → `overflow`=0.
- **Empty boundary:** at count=0, `wr_en` (8'h5A) with `tx_started` → `count`=1, `tx_data`=8'h5A, `underflow`=1. A `clr_errs` coinciding with another empty pop leaves `underflow`=1.
- **Steady state:** at count=3, push and pop simultaneously for 20 cycles → `count` stays 3 and output order is preserved.
- **End-to-end:** connect to the UART transmitter at 19200 baud, push 8'h48, 8'h69 back-to-back. Required: TX shows two frames, LSB first with start/stop bits, the second frame starting right after the first stop bit. `count` returns to 0 and `underflow` stays 0.

Source files
------------

// File: rtl/uart_tx_queue.sv
// Transmit byte queue feeding the UART transmitter: circular buffer with a
// first-word-fall-through head, occupancy count and sticky error flags.
module uart_tx_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     tx_started,
    input  logic                     clr_errs,
    output logic                     queue_not_empty,
    output logic [WIDTH-1:0]         tx_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [CW-1:0]    count_next;
    logic             overflow_reg;
    logic             overflow_next;
    logic             underflow_reg;
    logic             underflow_next;

    logic push_acc;
    logic push_rej;
    logic pop_acc;
    logic pop_ign;

    // Status comes only from the count register, so no input reaches an output
    assign queue_not_empty = (count_reg != '0);
    assign full            = (count_reg == CW'(DEPTH));
    assign tx_data         = queue_not_empty ? mem[rd_ptr_reg] : '0;
    assign count           = count_reg;
    assign overflow        = overflow_reg;
    assign underflow       = underflow_reg;

    // A full queue refuses the push even when a pop frees a slot this cycle
    assign push_acc = wr_en && !full;
    assign push_rej = wr_en && full;
    assign pop_acc  = tx_started && queue_not_empty;
    assign pop_ign  = tx_started && !queue_not_empty;

    always_comb begin
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;

        case ({push_acc, pop_acc})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase

        // An error event in the same cycle as a clear keeps the flag set
        if (push_rej) begin
            overflow_next = 1'b1;
        end else if (clr_errs) begin
            overflow_next = 1'b0;
        end

        if (pop_ign) begin
            underflow_next = 1'b1;
        end else if (clr_errs) begin
            underflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_acc) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    // Storage is deliberately left out of reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: directed vector table, hand-written corner sequences,
// randomized traffic against a queue model, and a UART end-to-end frame check.
module tb_uart_tx_queue;

    localparam int DEPTH = 8;
    localparam int BIT   = 2604;   // 50 MHz / 19200 baud

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       pop_main;
    logic       pop_uart;
    logic       tx_started;
    logic       clr_errs;
    logic       queue_not_empty;
    logic [7:0] tx_data;
    logic       full;
    logic [3:0] count;
    logic       overflow;
    logic       underflow;
    logic       serial;
    int         cyc;

    int n_pass;
    int n_total;

    assign tx_started = pop_main | pop_uart;

    uart_tx_queue #(.DEPTH(DEPTH), .WIDTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .tx_started      (tx_started),
        .clr_errs        (clr_errs),
        .queue_not_empty (queue_not_empty),
        .tx_data         (tx_data),
        .full            (full),
        .count           (count),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog");
    end

    // Reference model: an ordered byte queue plus two sticky flags
    logic [7:0] q_m[$];
    bit         ovf_m;
    bit         unf_m;

    typedef struct {
        bit         wr;
        logic [7:0] d;
        bit         pop;
        bit         clr;
        int         cnt;
        logic [7:0] head;
        bit         ovf;
        bit         unf;
    } vec_t;

    vec_t       tbl[11];
    logic [7:0] e2e_exp[2];
    int         start_c[2];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        q_m.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
    endtask

    task automatic model_apply(input bit wr, input logic [7:0] d, input bit pop, input bit clr);
        int sz;
        sz = q_m.size();
        if (wr && sz == DEPTH) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        if (pop && sz == 0) unf_m = 1'b1;
        else if (clr) unf_m = 1'b0;
        if (pop && sz > 0) void'(q_m.pop_front());
        if (wr && sz < DEPTH) q_m.push_back(d);
    endtask

    task automatic step(input bit wr, input logic [7:0] d, input bit pop, input bit clr);
        wr_en    = wr;
        wr_data  = d;
        pop_main = pop;
        clr_errs = clr;
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        pop_main = 1'b0;
        clr_errs = 1'b0;
        model_apply(wr, d, pop, clr);
        $display("cyc %0d wr=%0b d=%02h pop=%0b clr=%0b -> count=%0d head=%02h ovf=%0b unf=%0b",
                 cyc, wr, d, pop, clr, count, tx_data, overflow, underflow);
    endtask

    task automatic compare_model(input string tag);
        logic [7:0] h;
        h = (q_m.size() != 0) ? q_m[0] : 8'h00;
        chk({tag, "_count"}, int'(count), q_m.size());
        chk({tag, "_head"}, int'(tx_data), int'(h));
        chk({tag, "_ne"}, int'(queue_not_empty), int'(q_m.size() != 0));
        chk({tag, "_full"}, int'(full), int'(q_m.size() == DEPTH));
        chk({tag, "_ovf"}, int'(overflow), int'(ovf_m));
        chk({tag, "_unf"}, int'(underflow), int'(unf_m));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic uart_drive(input int n);
        logic [7:0] b;
        int w;
        for (int f = 0; f < n; f++) begin
            w = 0;
            while (!queue_not_empty && w < 100) begin
                wait_cyc(1);
                w++;
            end
            chk($sformatf("uart_wait%0d", f), int'(queue_not_empty), 1);
            if (!queue_not_empty) return;
            b = tx_data;            // init cycle: sample head
            wait_cyc(1);
            pop_uart = 1'b1;        // following cycle: pop and start bit
            serial   = 1'b0;
            wait_cyc(1);
            pop_uart = 1'b0;
            wait_cyc(BIT - 1);
            for (int i = 0; i < 8; i++) begin
                serial = b[i];
                wait_cyc(BIT);
            end
            serial = 1'b1;
            wait_cyc(BIT);
        end
    endtask

    task automatic uart_rx();
        logic [7:0] rb;
        int w;
        for (int k = 0; k < 2; k++) begin
            w = 0;
            while (serial && w < 4 * BIT) begin
                wait_cyc(1);
                w++;
            end
            chk($sformatf("rx_start_seen%0d", k), int'(serial), 0);
            if (serial) return;
            start_c[k] = cyc;
            wait_cyc(BIT / 2);
            chk($sformatf("rx_startbit%0d", k), int'(serial), 0);
            for (int i = 0; i < 8; i++) begin
                wait_cyc(BIT);
                rb[i] = serial;
            end
            wait_cyc(BIT);
            chk($sformatf("rx_stopbit%0d", k), int'(serial), 1);
            chk($sformatf("rx_byte%0d", k), int'(rb), int'(e2e_exp[k]));
            $display("uart frame %0d received %02h at cycle %0d", k, rb, start_c[k]);
        end
        chk("frame_gap", int'((start_c[1] - start_c[0] - 10 * BIT) <= 2), 1);
    endtask

    initial begin
        logic [7:0] exp_h;
        bit w;
        bit p;

        n_pass  = 0;
        n_total = 0;
        e2e_exp[0] = 8'h48;
        e2e_exp[1] = 8'h69;

        //          wr  d      pop  clr  cnt head   ovf  unf
        tbl[0]  = '{1, 8'hA5, 0,   0,   1, 8'hA5, 0,   0};
        tbl[1]  = '{0, 8'h00, 1,   0,   0, 8'h00, 0,   0};
        tbl[2]  = '{0, 8'h00, 1,   0,   0, 8'h00, 0,   1};
        tbl[3]  = '{0, 8'h00, 1,   1,   0, 8'h00, 0,   1};
        tbl[4]  = '{0, 8'h00, 0,   1,   0, 8'h00, 0,   0};
        tbl[5]  = '{1, 8'h5A, 1,   0,   1, 8'h5A, 0,   1};
        tbl[6]  = '{0, 8'h00, 0,   1,   1, 8'h5A, 0,   0};
        tbl[7]  = '{1, 8'h11, 1,   0,   1, 8'h11, 0,   0};
        tbl[8]  = '{1, 8'h22, 0,   0,   2, 8'h11, 0,   0};
        tbl[9]  = '{0, 8'h00, 1,   0,   1, 8'h22, 0,   0};
        tbl[10] = '{0, 8'h00, 1,   0,   0, 8'h00, 0,   0};

        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; pop_main = 1'b0;
        pop_uart = 1'b0; clr_errs = 1'b0; serial = 1'b1;
        wait_cyc(2);
        chk("rst_count", int'(count), 0);
        chk("rst_ne", int'(queue_not_empty), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_txdata", int'(tx_data), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst_unf", int'(underflow), 0);
        rst = 1'b0;
        model_clear();

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].wr, tbl[i].d, tbl[i].pop, tbl[i].clr);
            chk($sformatf("tbl%0d_count", i), int'(count), tbl[i].cnt);
            chk($sformatf("tbl%0d_head", i), int'(tx_data), int'(tbl[i].head));
            chk($sformatf("tbl%0d_ne", i), int'(queue_not_empty), int'(tbl[i].cnt != 0));
            chk($sformatf("tbl%0d_ovf", i), int'(overflow), int'(tbl[i].ovf));
            chk($sformatf("tbl%0d_unf", i), int'(underflow), int'(tbl[i].unf));
        end

        // Ordering and pointer wrap
        do_reset();
        for (int i = 1; i <= 8; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("wrap_full", int'(full), 1);
        chk("wrap_count8", int'(count), 8);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("wrap_head04", int'(tx_data), 8'h04);
        chk("wrap_count5", int'(count), 5);
        for (int i = 9; i <= 11; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("wrap_refull", int'(full), 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wrap_drain%0d", i), int'(tx_data), 4 + i);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("wrap_empty_ne", int'(queue_not_empty), 0);
        chk("wrap_empty_data", int'(tx_data), 0);
        chk("wrap_no_ovf", int'(overflow), 0);

        // Full boundary: push+pop on full rejects the push
        for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b1, 1'b0);
        chk("fullb_count", int'(count), 7);
        chk("fullb_ovf", int'(overflow), 1);
        chk("fullb_full", int'(full), 0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("fullb_clr", int'(overflow), 0);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("fullb_drain%0d", i), int'(tx_data), 8'h11 + i);
            step(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("fullb_empty", int'(queue_not_empty), 0);

        // Asynchronous reset in the middle of a cycle
        for (int i = 0; i < 5; i++) step(1'b1, 8'h60 + 8'(i), 1'b0, 1'b0);
        chk("mrst_count5", int'(count), 5);
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_async_count", int'(count), 0);
        chk("mrst_async_ne", int'(queue_not_empty), 0);
        chk("mrst_async_data", int'(tx_data), 0);
        wait_cyc(1);
        chk("mrst_hold_count", int'(count), 0);
        rst = 1'b0;
        model_clear();
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        chk("mrst_push_data", int'(tx_data), 8'hA5);
        chk("mrst_push_ne", int'(queue_not_empty), 1);

        // Steady state at count 3 with simultaneous push and pop
        do_reset();
        step(1'b1, 8'hC0, 1'b0, 1'b0);
        step(1'b1, 8'hC1, 1'b0, 1'b0);
        step(1'b1, 8'hC2, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 8'h30 + 8'(i), 1'b1, 1'b0);
            exp_h = (i == 0) ? 8'hC1 : (i == 1) ? 8'hC2 : 8'h30 + 8'(i - 2);
            chk($sformatf("steady%0d_count", i), int'(count), 3);
            chk($sformatf("steady%0d_head", i), int'(tx_data), int'(exp_h));
        end

        // Randomized traffic against the model, fill-biased then drain-biased
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i < 200) begin
                w = ($urandom_range(3) != 0);
                p = ($urandom_range(3) == 0);
            end else begin
                w = ($urandom_range(3) == 0);
                p = ($urandom_range(3) != 0);
            end
            step(w, 8'($urandom), p, $urandom_range(15) == 0);
            compare_model($sformatf("rnd%0d", i));
        end

        // End-to-end with a behavioural UART transmitter
        do_reset();
        fork
            begin
                step(1'b1, 8'h48, 1'b0, 1'b0);
                step(1'b1, 8'h69, 1'b0, 1'b0);
            end
            uart_drive(2);
            uart_rx();
        join
        chk("e2e_count", int'(count), 0);
        chk("e2e_unf", int'(underflow), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
